dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the CPU load/store path (driven by the decoder's MemRead/MemWrite) and the FFT accelerator's butterfly engine.
- Grants at most one access per cycle and returns read data one cycle later to the granted requester.
- Tags each read so data routes to the correct owner, and raises a stall to the CPU pipeline while the CPU waits.
- FFT may stream bursts; CPU wait is bounded by MAX_BURST cycles.

---
 rtl/dmem_arb_pkg.sv | 24 ++
 rtl/dmem_arb_grant.sv | 60 ++++++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter: FSM states, owner tags, size constants.
// No logic lives here; the grant unit and top both import it.
package dmem_arb_pkg;

  localparam int DEF_AW        = 10;
  localparam int DEF_DW        = 32;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU_OWN   = 2'd1,
    FFT_BURST = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_FFT = 1'b1
  } owner_e;

  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// CPU/FFT grant decision (combinational, 0 cycles) plus ownership state, FFT burst count and fairness flag.
// A losing requester simply sees no grant and must hold its request; the CPU waits at most MAX_BURST cycles.
module dmem_arb_grant
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_req,
  input  logic fft_req,
  output logic cpu_gnt,
  output logic fft_gnt
);

  localparam int CW = burst_cnt_w(MAX_BURST);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          fft_turn_q, fft_turn_d;
  logic          burst_open;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      fft_turn_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      fft_turn_q  <= fft_turn_d;
    end
  end

  always_comb begin
    burst_open  = (state_q == FFT_BURST) && (burst_cnt_q < CNT_MAX);
    // FFT keeps a running burst, or takes the turn the CPU owes it after a CPU win.
    fft_gnt     = fft_req & (~cpu_req | burst_open | ((state_q != FFT_BURST) & fft_turn_q));
    cpu_gnt     = cpu_req & ~fft_gnt;

    state_d     = IDLE;
    burst_cnt_d = '0;
    fft_turn_d  = fft_turn_q;

    if (fft_gnt) begin
      state_d    = FFT_BURST;
      fft_turn_d = 1'b0;
      if (state_q == FFT_BURST) begin
        burst_cnt_d = (burst_cnt_q == CNT_MAX) ? CNT_MAX : burst_cnt_q + CW'(1);
      end else begin
        burst_cnt_d = CW'(1);
      end
    end else if (cpu_gnt) begin
      state_d    = CPU_OWN;
      fft_turn_d = fft_req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter for CPU load/store and FFT butterfly engine; grant same cycle, read data +1 cycle.
// Loser stalls (cpu_stall for CPU) holding its request; DMEM_ARB_PERF_EN adds stall/grant performance counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          fft_req,
  input  logic          fft_we,
  input  logic [AW-1:0] fft_addr,
  input  logic [DW-1:0] fft_wdata,
  output logic          fft_gnt,
  output logic          fft_rvalid,
  output logic [DW-1:0] fft_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  input  logic          perf_clr,
  output logic [31:0]   cpu_stall_cnt,
  output logic [31:0]   fft_gnt_cnt
`endif
);

  owner_e own;
  logic   cpu_rd_q, cpu_rd_d;
  logic   fft_rd_q, fft_rd_d;

  dmem_arb_grant #(
    .MAX_BURST(MAX_BURST)
  ) u_grant (
    .clk     (clk),
    .rst_n   (rst_n),
    .cpu_req (cpu_req),
    .fft_req (fft_req),
    .cpu_gnt (cpu_gnt),
    .fft_gnt (fft_gnt)
  );

  always_comb begin
    own       = fft_gnt ? OWN_FFT : OWN_CPU;
    mem_en    = cpu_gnt | fft_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_en) begin
      if (own == OWN_FFT) begin
        mem_we    = fft_we;
        mem_addr  = fft_addr;
        mem_wdata = fft_wdata;
      end else begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
    end
    cpu_stall = cpu_req & ~cpu_gnt;
    cpu_rd_d  = cpu_gnt & ~cpu_we;
    fft_rd_d  = fft_gnt & ~fft_we;
  end

  // Read tag: one flag per owner marks whose data comes back from memory next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rd_q <= 1'b0;
      fft_rd_q <= 1'b0;
    end else begin
      cpu_rd_q <= cpu_rd_d;
      fft_rd_q <= fft_rd_d;
    end
  end

  assign cpu_rvalid = cpu_rd_q;
  assign fft_rvalid = fft_rd_q;
  assign cpu_rdata  = mem_rdata;
  assign fft_rdata  = mem_rdata;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] cpu_stall_cnt_q, cpu_stall_cnt_d;
  logic [31:0] fft_gnt_cnt_q, fft_gnt_cnt_d;

  always_comb begin
    cpu_stall_cnt_d = cpu_stall_cnt_q;
    fft_gnt_cnt_d   = fft_gnt_cnt_q;
    if (perf_clr) begin
      cpu_stall_cnt_d = '0;
      fft_gnt_cnt_d   = '0;
    end else begin
      if (cpu_stall && (cpu_stall_cnt_q != '1)) cpu_stall_cnt_d = cpu_stall_cnt_q + 32'd1;
      if (fft_gnt && (fft_gnt_cnt_q != '1))     fft_gnt_cnt_d   = fft_gnt_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_stall_cnt_q <= '0;
      fft_gnt_cnt_q   <= '0;
    end else begin
      cpu_stall_cnt_q <= cpu_stall_cnt_d;
      fft_gnt_cnt_q   <= fft_gnt_cnt_d;
    end
  end

  assign cpu_stall_cnt = cpu_stall_cnt_q;
  assign fft_gnt_cnt   = fft_gnt_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, fft_req, fft_we;
  logic [AW-1:0] cpu_addr, fft_addr;
  logic [DW-1:0] cpu_wdata, fft_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid, fft_gnt, fft_rvalid;
  logic [DW-1:0] cpu_rdata, fft_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic          perf_clr = 1'b0;
  logic [31:0]   cpu_stall_cnt, fft_gnt_cnt;
`endif

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .fft_req(fft_req), .fft_we(fft_we), .fft_addr(fft_addr), .fft_wdata(fft_wdata),
    .fft_gnt(fft_gnt), .fft_rvalid(fft_rvalid), .fft_rdata(fft_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_clr(perf_clr), .cpu_stall_cnt(cpu_stall_cnt), .fft_gnt_cnt(fft_gnt_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Environment memory: synchronous-read single-port RAM driven by the DUT.
  logic [DW-1:0] env_mem [0:1023];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) env_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= env_mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic          cg, fg, st, en, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } exp_t;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } rd_t;

  exp_t exp_q[$];
  rd_t  crd_q[$];
  rd_t  frd_q[$];
  byte  gnt_log[$];

  // Reference model: fairness expressed as "consecutive FFT wins" and "FFT is owed the next contest".
  logic [DW-1:0] model_mem [0:1023];
  int  streak;
  bit  last_fft;
  bit  fft_owed;

  task automatic model_reset();
    streak   = 0;
    last_fft = 0;
    fft_owed = 0;
  endtask

  task automatic step(input bit c, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                      input bit f, input bit fw, input logic [AW-1:0] fa, input logic [DW-1:0] fd,
                      output bit gc, output bit gf);
    exp_t e;
    rd_t  r;
    cpu_req = c; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    fft_req = f; fft_we = fw; fft_addr = fa; fft_wdata = fd;
    if (!f)           gf = 0;
    else if (!c)      gf = 1;
    else if (last_fft) gf = (streak < MB);
    else              gf = fft_owed;
    gc = c && !gf;
    e.cg = gc; e.fg = gf; e.st = c && !gc; e.en = gc || gf;
    e.we = gf ? fw : (gc ? cw : 1'b0);
    e.addr = gf ? fa : (gc ? ca : '0);
    e.wd   = gf ? fd : (gc ? cd : '0);
    exp_q.push_back(e);
    r.due = cyc + 1;
    if (gf) begin
      if (fw) model_mem[fa] = fd;
      else begin r.d = model_mem[fa]; frd_q.push_back(r); end
      streak   = last_fft ? ((streak + 1 > MB) ? MB : streak + 1) : 1;
      last_fft = 1;
      fft_owed = 0;
    end else if (gc) begin
      if (cw) model_mem[ca] = cd;
      else begin r.d = model_mem[ca]; crd_q.push_back(r); end
      streak   = 0;
      last_fft = 0;
      fft_owed = f;
    end else begin
      streak   = 0;
      last_fft = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    fft_req = 0; fft_we = 0; fft_addr = '0; fft_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    exp_q.delete(); crd_q.delete(); frd_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every live cycle compare grants/mux against the scoreboard and rvalids against read tags.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      gnt_log.push_back(fft_gnt ? "F" : (cpu_gnt ? "C" : "-"));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant_cpu_fft_stall", {61'd0, cpu_gnt, fft_gnt, cpu_stall}, {61'd0, e.cg, e.fg, e.st});
        chk("mem_en_we", {62'd0, mem_en, mem_we}, {62'd0, e.en, e.we});
        chk("mem_addr", 64'(mem_addr), 64'(e.addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(e.wd));
      end
      if (crd_q.size() > 0 && crd_q[0].due == cyc) begin
        chk("cpu_rvalid", 64'(cpu_rvalid), 64'd1);
        chk("cpu_rdata", 64'(cpu_rdata), 64'(crd_q[0].d));
        void'(crd_q.pop_front());
      end else begin
        chk("cpu_rvalid_idle", 64'(cpu_rvalid), 64'd0);
      end
      if (frd_q.size() > 0 && frd_q[0].due == cyc) begin
        chk("fft_rvalid", 64'(fft_rvalid), 64'd1);
        chk("fft_rdata", 64'(fft_rdata), 64'(frd_q[0].d));
        void'(frd_q.pop_front());
      end else begin
        chk("fft_rvalid_idle", 64'(fft_rvalid), 64'd0);
      end
    end
  end

  initial begin
    bit gc, gf;
    logic [DW-1:0] wr_dat [0:5];
    string pat;
    bit pc, pcw, pf, pfw;
    logic [AW-1:0] pca, pfa;
    logic [DW-1:0] pcd, pfd;

    for (int i = 0; i < 1024; i++) begin
      env_mem[i]   = 32'h5A00_0000 ^ (i * 32'h0001_0203);
      model_mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
    end
    env_mem[10'h010] = 32'hDEADBEEF; model_mem[10'h010] = 32'hDEADBEEF;
    env_mem[10'h020] = 32'h1234_5678; model_mem[10'h020] = 32'h1234_5678;
    env_mem[10'h021] = 32'hCAFE_F00D; model_mem[10'h021] = 32'hCAFE_F00D;

    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rvalids", {62'd0, cpu_rvalid, fft_rvalid}, 64'd0);
    chk("reset_idle_mem_en", 64'(mem_en), 64'd0);
    rst_n = 1'b1;

    // Solo CPU load.
    step(1, 0, 10'h010, '0, 0, 0, '0, '0, gc, gf);
    chk("solo_cpu_rvalid", {62'd0, cpu_rvalid, fft_rvalid}, 64'd2);
    chk("solo_cpu_rdata", 64'(cpu_rdata), 64'hDEADBEEF);
    step(0, 0, '0, '0, 0, 0, '0, '0, gc, gf);

    // Contention from reset: both requests held for 12 cycles.
    do_reset();
    gnt_log.delete();
    for (int i = 0; i < 12; i++) step(1, 0, AW'(10'h100 + i), '0, 1, 0, AW'(10'h200 + i), '0, gc, gf);
    pat = "CFFFFCFFFFCF";
    for (int i = 0; i < 12; i++) chk("contention_seq", 64'(gnt_log[i]), 64'(pat[i]));
    step(0, 0, '0, '0, 0, 0, '0, '0, gc, gf);

    // FFT write burst, CPU idle.
    for (int i = 0; i < 6; i++) begin
      wr_dat[i] = $urandom;
      step(0, 0, '0, '0, 1, 1, AW'(i), wr_dat[i], gc, gf);
    end
    for (int i = 0; i < 6; i++) chk("fft_burst_mem", 64'(env_mem[i]), 64'(wr_dat[i]));

    // Async reset with an FFT read in flight.
    step(0, 0, '0, '0, 1, 0, 10'h030, '0, gc, gf);
    step(0, 0, '0, '0, 1, 0, 10'h031, '0, gc, gf);
    chk("inflight_fft_rvalid", 64'(fft_rvalid), 64'd1);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("reset_drops_rvalid", {62'd0, cpu_rvalid, fft_rvalid}, 64'd0);
    do_reset();

    // After release both request: CPU first, then interleaved loads 0x020 / 0x021.
    gnt_log.delete();
    step(1, 0, 10'h020, '0, 1, 0, 10'h021, '0, gc, gf);
    chk("post_reset_cpu_first", 64'(gnt_log[0]), 64'("C"));
    step(0, 0, '0, '0, 1, 0, 10'h021, '0, gc, gf);
    step(0, 0, '0, '0, 0, 0, '0, '0, gc, gf);

    // Random traffic; a pending request is held until granted, with occasional drops.
    pc = 0; pf = 0;
    pcw = 0; pfw = 0; pca = '0; pfa = '0; pcd = '0; pfd = '0;
    for (int n = 0; n < 600; n++) begin
      if (pc && $urandom_range(0, 15) == 0) pc = 0;
      if (pf && $urandom_range(0, 15) == 0) pf = 0;
      if (!pc && $urandom_range(0, 9) < 6) begin
        pc = 1; pcw = $urandom_range(0, 1); pca = AW'($urandom_range(0, 31)); pcd = $urandom;
      end
      if (!pf && $urandom_range(0, 9) < 7) begin
        pf = 1; pfw = $urandom_range(0, 1); pfa = AW'($urandom_range(0, 31)); pfd = $urandom;
      end
      step(pc, pcw, pca, pcd, pf, pfw, pfa, pfd, gc, gf);
      if (gc) pc = 0;
      if (gf) pf = 0;
    end
    step(0, 0, '0, '0, 0, 0, '0, '0, gc, gf);
    step(0, 0, '0, '0, 0, 0, '0, '0, gc, gf);
    chk("drain_cpu_tags", 64'(crd_q.size()), 64'd0);
    chk("drain_fft_tags", 64'(frd_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
